// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Captures the control bundles (WB/M/EX), the register-file operands, the
// immediate and the register specifiers from ID and presents them to EX one
// cycle later. A bubble (all control zero, Valid_out=0, datapath zero) is
// loaded on a taken branch/jump (Flush) or on a load-use hazard. Hold freezes
// every register, including the bubble counter.
//
// Build option:
//   LOAD_USE_STALL_EN  defined   -> load-use detection active, Stall driven.
//                      undefined -> LoadHaz=0, Stall tied to 0; only Flush
//                                   inserts bubbles.
//
// Parameters:
//   CNT_W        width of the saturating BubbleCount.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   Hold                         freeze all state (memory wait)
//   Flush                        squash the instruction being captured
//   WB_in/M_in/EX_in             control bundles from Control
//   RsData_in/RtData_in/Imm_in   operands and sign-extended immediate
//   Rs_in/Rt_in/Rd_in            register specifiers from ID
//   *_out                        registered copies of the above
//   Valid_out                    stage holds a real instruction
//   Stall                        load-use hazard; PC and IF/ID must not advance
//   BubbleCount                  saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Hold,
  input  logic             Flush,
  input  logic [1:0]       WB_in,
  input  logic [3:0]       M_in,
  input  logic [7:0]       EX_in,
  input  logic [31:0]      RsData_in,
  input  logic [31:0]      RtData_in,
  input  logic [31:0]      Imm_in,
  input  logic [4:0]       Rs_in,
  input  logic [4:0]       Rt_in,
  input  logic [4:0]       Rd_in,
  output logic [1:0]       WB_out,
  output logic [3:0]       M_out,
  output logic [7:0]       EX_out,
  output logic [31:0]      RsData_out,
  output logic [31:0]      RtData_out,
  output logic [31:0]      Imm_out,
  output logic [4:0]       Rs_out,
  output logic [4:0]       Rt_out,
  output logic [4:0]       Rd_out,
  output logic             Valid_out,
  output logic             Stall,
  output logic [CNT_W-1:0] BubbleCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_wb;
  logic [3:0]       r_m;
  logic [7:0]       r_ex;
  logic [31:0]      r_rs_data;
  logic [31:0]      r_rt_data;
  logic [31:0]      r_imm;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_rd;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_load_haz;
  logic             w_load_bubble;

`ifdef LOAD_USE_STALL_EN
  // A load is recognised by MemtoReg+RegWrite: MemRead=00 also encodes a
  // halfword access, so it cannot distinguish loads. $zero never stalls.
  assign w_load_haz = r_valid & r_wb[1] & r_wb[0] & (r_rt != 5'd0) &
                      ((r_rt == Rs_in) | (r_rt == Rt_in));
`else
  assign w_load_haz = 1'b0;
`endif

  assign Stall         = w_load_haz & ~Flush & ~Hold;
  // Flush and a hazard together still produce a single bubble.
  assign w_load_bubble = Flush | w_load_haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb         <= '0;
      r_m          <= '0;
      r_ex         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (Hold) begin
      // Freeze everything; a Flush arriving now is dropped and re-presented.
    end else if (w_load_bubble) begin
      r_wb      <= '0;
      r_m       <= '0;
      r_ex      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_valid   <= 1'b0;
      if (r_bubble_cnt != '1) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end else begin
      r_wb      <= WB_in;
      r_m       <= M_in;
      r_ex      <= EX_in;
      r_rs_data <= RsData_in;
      r_rt_data <= RtData_in;
      r_imm     <= Imm_in;
      r_rs      <= Rs_in;
      r_rt      <= Rt_in;
      r_rd      <= Rd_in;
      r_valid   <= 1'b1;
    end
  end

  assign WB_out      = r_wb;
  assign M_out       = r_m;
  assign EX_out      = r_ex;
  assign RsData_out  = r_rs_data;
  assign RtData_out  = r_rt_data;
  assign Imm_out     = r_imm;
  assign Rs_out      = r_rs;
  assign Rt_out      = r_rt;
  assign Rd_out      = r_rd;
  assign Valid_out   = r_valid;
  assign BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
// Two instances share all inputs: the default CNT_W=16 one, and a CNT_W=2
// one whose BubbleCount exercises saturation. A behavioural model tracks the
// expected contents of the stage and both bubble counts.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Hold, Flush;
  logic [1:0]  WB_in;
  logic [3:0]  M_in;
  logic [7:0]  EX_in;
  logic [31:0] RsData_in, RtData_in, Imm_in;
  logic [4:0]  Rs_in, Rt_in, Rd_in;

  logic [1:0]  WB_out, WB_out2;
  logic [3:0]  M_out, M_out2;
  logic [7:0]  EX_out, EX_out2;
  logic [31:0] RsData_out, RtData_out, Imm_out;
  logic [31:0] RsData_out2, RtData_out2, Imm_out2;
  logic [4:0]  Rs_out, Rt_out, Rd_out, Rs_out2, Rt_out2, Rd_out2;
  logic        Valid_out, Valid_out2, Stall, Stall2;
  logic [15:0] BubbleCount;
  logic [1:0]  BubbleCount2;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .Hold(Hold), .Flush(Flush),
    .WB_in(WB_in), .M_in(M_in), .EX_in(EX_in),
    .RsData_in(RsData_in), .RtData_in(RtData_in), .Imm_in(Imm_in),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
    .WB_out(WB_out), .M_out(M_out), .EX_out(EX_out),
    .RsData_out(RsData_out), .RtData_out(RtData_out), .Imm_out(Imm_out),
    .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out),
    .Valid_out(Valid_out), .Stall(Stall), .BubbleCount(BubbleCount)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .Hold(Hold), .Flush(Flush),
    .WB_in(WB_in), .M_in(M_in), .EX_in(EX_in),
    .RsData_in(RsData_in), .RtData_in(RtData_in), .Imm_in(Imm_in),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
    .WB_out(WB_out2), .M_out(M_out2), .EX_out(EX_out2),
    .RsData_out(RsData_out2), .RtData_out(RtData_out2), .Imm_out(Imm_out2),
    .Rs_out(Rs_out2), .Rt_out(Rt_out2), .Rd_out(Rd_out2),
    .Valid_out(Valid_out2), .Stall(Stall2), .BubbleCount(BubbleCount2)
  );

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [1:0]  m_wb;
  logic [3:0]  m_m;
  logic [7:0]  m_ex;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt, m_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic model_clear();
    m_valid = 0; m_wb = 0; m_m = 0; m_ex = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
  endtask

  // Instruction in EX is a load whose destination is read by the one in ID.
  function automatic bit model_haz();
    return STALL_EN && m_valid && (m_wb == 2'b11) && (m_rt != 0) &&
           ((m_rt == Rs_in) || (m_rt == Rt_in));
  endfunction

  function automatic bit model_stall();
    return model_haz() && !Flush && !Hold;
  endfunction

  function automatic logic [143:0] exp_pack();
    return {m_wb, m_m, m_ex, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_valid,
            16'(m_cnt), 2'(m_cnt2)};
  endfunction

  function automatic logic [143:0] obs_pack();
    return {WB_out, M_out, EX_out, RsData_out, RtData_out, Imm_out,
            Rs_out, Rt_out, Rd_out, Valid_out, BubbleCount, BubbleCount2};
  endfunction

  // Advance one clock edge and update the model from the inputs at the edge.
  task automatic tick();
    bit haz;
    @(posedge clk);
    haz = model_haz();
    if (!Hold) begin
      if (Flush || haz) begin
        model_clear();
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end else begin
        m_valid = 1; m_wb = WB_in; m_m = M_in; m_ex = EX_in;
        m_rsd = RsData_in; m_rtd = RtData_in; m_imm = Imm_in;
        m_rs = Rs_in; m_rt = Rt_in; m_rd = Rd_in;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [7:0] ex,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    WB_in = wb; EX_in = ex; M_in = 4'($urandom);
    RsData_in = $urandom; RtData_in = $urandom; Imm_in = $urandom;
    Rs_in = rs; Rt_in = rt; Rd_in = rd;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Hold = 0; Flush = 0;
    drive(2'b11, 8'hff, 5'd1, 5'd2, 5'd3);
    rst_n = 0;
    #1;
    model_clear(); m_cnt = 0; m_cnt2 = 0;
    n_checks++;
    if (obs_pack() !== exp_pack()) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs_pack(), exp_pack());
    end
    n_checks++;
    if (Stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stall: got %b expected 0", Stall);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    drive(2'b11, 8'h80, 5'd4, 5'd9, 5'd0);          // lw $t1
    tick();
    drive(2'b01, 8'h02, 5'd9, 5'd3, 5'd10);         // consumer of $t1
    n_checks++;
    if (Stall !== model_stall() || Stall !== STALL_EN) begin
      n_errors++;
      $display("FAIL load_use_stall: got %b expected %b", Stall, STALL_EN);
    end
    tick();
    n_checks++;
    if (obs_pack() !== exp_pack() || Valid_out !== !STALL_EN) begin
      n_errors++;
      $display("FAIL load_use_bubble: got %h expected %h", obs_pack(), exp_pack());
    end
    n_checks++;
    if (Stall !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_one_cycle: got Stall=%b expected 0", Stall);
    end
    tick();
    n_checks++;
    if (obs_pack() !== exp_pack() || Valid_out !== 1'b1) begin
      n_errors++;
      $display("FAIL load_use_resume: got %h expected %h", obs_pack(), exp_pack());
    end
  endtask

  task automatic test_rt_zero();
    int c0;
    c0 = m_cnt;
    drive(2'b11, 8'h80, 5'd5, 5'd0, 5'd0);          // load into $zero
    tick();
    drive(2'b01, 8'h01, 5'd0, 5'd0, 5'd7);
    n_checks++;
    if (Stall !== 1'b0) begin
      n_errors++;
      $display("FAIL rt_zero_stall: got %b expected 0", Stall);
    end
    tick();
    n_checks++;
    if (obs_pack() !== exp_pack() || Valid_out !== 1'b1 || m_cnt != c0) begin
      n_errors++;
      $display("FAIL rt_zero_capture: got %h expected %h", obs_pack(), exp_pack());
    end
  endtask

  task automatic test_flush();
    int c0;
    c0 = BubbleCount;
    drive(2'b01, 8'h80, 5'd2, 5'd8, 5'd0);          // addi
    Flush = 1; #1;
    tick();
    Flush = 0;
    n_checks++;
    if (obs_pack() !== exp_pack() || Valid_out !== 1'b0 || EX_out !== 8'h00) begin
      n_errors++;
      $display("FAIL flush_bubble: got %h expected %h", obs_pack(), exp_pack());
    end
    n_checks++;
    if (int'(BubbleCount) !== c0 + 1) begin
      n_errors++;
      $display("FAIL flush_count: got %0d expected %0d", BubbleCount, c0 + 1);
    end
  endtask

  task automatic test_hold();
    logic [143:0] frozen;
    drive(2'b11, 8'h80, 5'd1, 5'd12, 5'd0);         // load so Hold must mask Stall
    tick();
    frozen = obs_pack();
    Hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(2'($urandom), 8'($urandom), 5'd12, 5'($urandom), 5'($urandom));
      Flush = (i == 1);
      #1;
      n_checks++;
      if (Stall !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_stall_masked: got %b expected 0 (cycle %0d)", Stall, i);
      end
      tick();
      n_checks++;
      if (obs_pack() !== frozen || obs_pack() !== exp_pack()) begin
        n_errors++;
        $display("FAIL hold_frozen: got %h expected %h (cycle %0d)", obs_pack(), frozen, i);
      end
    end
    Hold = 0; Flush = 0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      drive(2'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      Flush = 1; #1;
      tick();
    end
    Flush = 0;
    n_checks++;
    if (BubbleCount2 !== 2'd3 || obs_pack() !== exp_pack()) begin
      n_errors++;
      $display("FAIL cnt_saturate: got cnt2=%0d all=%h expected cnt2=3 all=%h",
               BubbleCount2, obs_pack(), exp_pack());
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(2'b11, 8'h80, 5'd3, 5'd17, 5'd0);
    tick();
    drive(2'b01, 8'h03, 5'd17, 5'd4, 5'd21);
    n_checks++;
    if (Stall !== STALL_EN) begin
      n_errors++;
      $display("FAIL mid_stall_setup: got %b expected %b", Stall, STALL_EN);
    end
    rst_n = 0;
    #1;
    model_clear(); m_cnt = 0; m_cnt2 = 0;
    n_checks++;
    if (obs_pack() !== exp_pack() || Stall !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_stall_reset: got %h stall=%b expected %h stall=0",
               obs_pack(), Stall, exp_pack());
    end
    #1 rst_n = 1;
    drive(2'b01, 8'h05, 5'd17, 5'd4, 5'd22);        // R-type reading old load dest
    tick();
    n_checks++;
    if (obs_pack() !== exp_pack() || Valid_out !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_capture: got %h expected %h", obs_pack(), exp_pack());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom), 8'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom));
      Flush = ($urandom_range(0, 7) == 0);
      Hold  = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++;
      if (Stall !== model_stall()) begin
        n_errors++;
        $display("FAIL rand_stall: got %b expected %b (iter %0d)", Stall, model_stall(), i);
      end
      tick();
      n_checks++;
      if (obs_pack() !== exp_pack()) begin
        n_errors++;
        $display("FAIL rand_state: got %h expected %h (iter %0d)", obs_pack(), exp_pack(), i);
      end
    end
    Hold = 0; Flush = 0;
  endtask

  initial begin
    rst_n = 0; Hold = 0; Flush = 0;
    WB_in = 0; M_in = 0; EX_in = 0; RsData_in = 0; RtData_in = 0; Imm_in = 0;
    Rs_in = 0; Rt_in = 0; Rd_in = 0;
    #7;
    test_reset();
    test_load_use();
    test_rt_zero();
    test_flush();
    test_hold();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of BubbleCount.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Hold  in  1  external freeze (memory wait); register contents held.
- Flush  in  1  taken branch/jump in ID; squash the instruction being captured.
- WB_in  in  2  {MemtoReg, RegWrite} from Control.
- M_in  in  4  {MemRead[1:0], MemWrite[1:0]} from Control.
- EX_in  in  8  {ALUSrc, ALUOp[5:0], RegDst} from Control.
- RsData_in  in  32  register file port 1.
- RtData_in  in  32  register file port 2.
- Imm_in  in  32  sign-extended immediate.
- Rs_in  in  5  ID source register.
- Rt_in  in  5  ID target register.
- Rd_in  in  5  ID destination register.
- WB_out  out  2  registered WB.
- M_out  out  4  registered M.
- EX_out  out  8  registered EX.
- RsData_out  out  32  registered RsData.
- RtData_out  out  32  registered RtData.
- Imm_out  out  32  registered Imm.
- Rs_out  out  5  registered Rs.
- Rt_out  out  5  registered Rt.
- Rd_out  out  5  registered Rd.
- Valid_out  out  1  stage holds a real instruction (not a bubble).
- Stall  out  1  load-use hazard; PC and IF/ID shall not advance.
- BubbleCount  out  CNT_W  saturating count of inserted bubbles.

Function
REQ-003 A bubble SHALL be defined as WB_out=0, M_out=0, EX_out=0, Valid_out=0; datapath fields are don't-care but SHALL be cleared to 0.
REQ-004 LoadHaz SHALL be combinational: Valid_out & WB_out[1] & WB_out[0] & (Rt_out!=0) & (Rt_out==Rs_in | Rt_out==Rt_in).
- Load detection SHALL use MemtoReg, not MemRead, because MemRead=00 also encodes halfword.
REQ-005 Stall SHALL equal LoadHaz & ~Flush & ~Hold.
REQ-006 On each rising clk edge, the highest-priority true case SHALL apply:
- Hold: all registers keep their values.
- Flush: bubble is loaded.
- LoadHaz: bubble is loaded.
- Otherwise: all *_in inputs are captured, Valid_out=1.
REQ-007 Latency SHALL be one cycle, ID inputs to *_out.
REQ-008 With Stall=1, the following cycle SHALL show a bubble and LoadHaz=0 (Valid_out=0), so a stall lasts exactly one cycle per load-use pair.
REQ-009 BubbleCount SHALL increment by 1 on each edge that loads a bubble (Flush or LoadHaz, Hold=0), and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-010 Flush and LoadHaz in the same cycle SHALL count once.
REQ-011 Hold asserted together with Flush SHALL freeze; the flush is lost, and the branch unit SHALL re-present it.
REQ-012 A register-0 destination SHALL never cause a stall.

Reset
REQ-013 While rst_n=0, asynchronously, all outputs SHALL be 0 (bubble state, Valid_out=0, BubbleCount=0, Stall=0).
REQ-014 Reset asserted mid-stall SHALL discard the pending hazard; the first edge after release SHALL capture inputs normally.

Configuration
REQ-015 With LOAD_USE_STALL_EN defined, REQ-004/005/008 SHALL apply.
REQ-016 With LOAD_USE_STALL_EN undefined, LoadHaz SHALL be 0 and Stall SHALL be tied to 0, and only Flush SHALL insert bubbles.

Verification
REQ-017 The bench SHALL cover the following scenarios:
- Reset then lw $t1 (WB_in=11, Rt_in=9), next ID Rs_in=9 -> Stall=1 one cycle; next edge bubble; BubbleCount=1.
- lw with Rt=0 followed by Rs_in=0 -> Stall=0, no bubble.
- addi (WB_in=01, EX_in[7]=1) with Flush=1 -> next cycle Valid_out=0, EX_out=0, BubbleCount+1.
- Hold=1 for 3 cycles with changing inputs -> outputs constant; Flush during Hold -> no bubble, count unchanged.
- CNT_W=2, 5 flushes -> BubbleCount=3.
- rst_n low mid-cycle during Stall -> outputs 0 immediately; after release, R-type captured with Valid_out=1.
